// File: rtl/route_pkg.sv
// Shared types and host command encodings for the route sequencer.
package route_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DEP,
        WAIT_ARR,
        DWELL
    } rs_state_t;

    localparam logic [1:0] STOP_CMD  = 2'b00;
    localparam logic [1:0] GO_CMD    = 2'b01;
    localparam logic [1:0] QUEUE_CMD = 2'b10;
    localparam logic [1:0] ROUTE_CMD = 2'b11;

    localparam logic [1:0] RUN_ONCE  = 2'b00;
    localparam logic [1:0] RUN_LOOP  = 2'b01;
    localparam logic [1:0] CLEAR     = 2'b10;
    localparam logic [1:0] RSVD      = 2'b11;

endpackage

// File: rtl/route_table.sv
// Route table: DEPTH x 6-bit station IDs, append-only with clear, async read.
module route_table
    import route_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [5:0]    wr_id,
    input  logic          clr,
    input  logic [PW-1:0] rd_ptr,
    output logic [5:0]    rd_id,
    output logic [CW-1:0] q_cnt,
    output logic          full
);

    logic [5:0] mem [DEPTH];

    assign full  = (q_cnt == CW'(DEPTH));
    assign rd_id = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            q_cnt <= '0;
        end else if (wr_en && !full) begin
            mem[q_cnt[PW-1:0]] <= wr_id;
            q_cnt              <= q_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/route_sequencer.sv
// Schedules a multi-stop route to cmd_cntrl: one GO per stop, wait for arrival, dwell, next stop.
// Host STOP/GO commands are forwarded verbatim and abort any route in progress.
module route_sequencer
    import route_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DWELL_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   host_cmd,
    input  logic                         host_cmd_rdy,
    output logic                         clr_host_cmd_rdy,
    output logic [7:0]                   cmd,
    output logic                         cmd_rdy,
    input  logic                         clr_cmd_rdy,
    input  logic                         in_transit,
    output logic                         route_busy,
    output logic                         route_done,
    output logic                         route_err,
    output logic [$clog2(DEPTH+1)-1:0]   q_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    rs_state_t     state_q, state_d;
    logic [7:0]    cmd_d;
    logic          cmd_rdy_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          loop_q, loop_d;
    logic          err_d, done_d;
    logic          host_acc;
    logic          tbl_we, tbl_clr, tbl_full;
    logic [5:0]    tbl_rd;

    route_table #(.DEPTH(DEPTH)) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (tbl_we),
        .wr_id  (host_cmd[5:0]),
        .clr    (tbl_clr),
        .rd_ptr (rd_ptr_q),
        .rd_id  (tbl_rd),
        .q_cnt  (q_cnt),
        .full   (tbl_full)
    );

    assign route_busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd        <= 8'h00;
            cmd_rdy    <= 1'b0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            loop_q     <= 1'b0;
            route_err  <= 1'b0;
            route_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd        <= cmd_d;
            cmd_rdy    <= cmd_rdy_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            loop_q     <= loop_d;
            route_err  <= err_d;
            route_done <= done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd;
        cmd_rdy_d        = cmd_rdy;
        rd_ptr_d         = rd_ptr_q;
        cnt_d            = cnt_q;
        loop_d           = loop_q;
        err_d            = route_err;
        done_d           = 1'b0;
        tbl_we           = 1'b0;
        tbl_clr          = 1'b0;
        host_acc         = host_cmd_rdy && !cmd_rdy;
        clr_host_cmd_rdy = host_acc;

        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

        // Route FSM first; an accepted host command below overrides it (host wins).
        case (state_q)
            ISSUE: begin
                if (!cmd_rdy) begin
                    cmd_d     = {GO_CMD, tbl_rd};
                    cmd_rdy_d = 1'b1;
                end else if (clr_cmd_rdy) begin
                    state_d = WAIT_DEP;
                end
            end
            WAIT_DEP: if (in_transit) state_d = WAIT_ARR;
            WAIT_ARR: begin
                if (!in_transit) begin
                    state_d = DWELL;
                    cnt_d   = '0;
                end
            end
            DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    if ((CW'(rd_ptr_q) + CW'(1)) < q_cnt) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        state_d  = ISSUE;
                    end else begin
                        rd_ptr_d = '0;
                        if (loop_q) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: ;
        endcase

        if (host_acc) begin
            case (host_cmd[7:6])
                STOP_CMD, GO_CMD: begin
                    cmd_d     = host_cmd;
                    cmd_rdy_d = 1'b1;
                    state_d   = IDLE;
                    rd_ptr_d  = '0;
                    done_d    = 1'b0;
                end
                QUEUE_CMD: begin
                    if (tbl_full) err_d = 1'b1;
                    else          tbl_we = 1'b1;
                end
                default: begin
                    case (host_cmd[1:0])
                        RUN_ONCE, RUN_LOOP: begin
                            if (state_q == IDLE) begin
                                if (q_cnt == '0) begin
                                    err_d = 1'b1;
                                end else begin
                                    state_d  = ISSUE;
                                    rd_ptr_d = '0;
                                    loop_d   = host_cmd[0];
                                end
                            end
                        end
                        CLEAR: begin
                            if (state_q == IDLE) begin
                                tbl_clr  = 1'b1;
                                rd_ptr_d = '0;
                                err_d    = 1'b0;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// Self-checking bench for route_sequencer: host driver, cmd_cntrl responder, queue-based route model.
module tb_route_sequencer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_cmd;
    logic       host_cmd_rdy;
    logic       clr_host_cmd_rdy;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic       in_transit;
    logic       route_busy;
    logic       route_done;
    logic       route_err;
    logic [3:0] q_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [5:0] m_tbl[$];
    bit         m_err = 0;
    bit         m_busy = 0;

    route_sequencer #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host_cmd         (host_cmd),
        .host_cmd_rdy     (host_cmd_rdy),
        .clr_host_cmd_rdy (clr_host_cmd_rdy),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .in_transit       (in_transit),
        .route_busy       (route_busy),
        .route_done       (route_done),
        .route_err        (route_err),
        .q_cnt            (q_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (route_done === 1'b1) done_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void model_host(input logic [7:0] c);
        case (c[7:6])
            2'b00, 2'b01: m_busy = 0;
            2'b10: if (m_tbl.size() == DEPTH) m_err = 1; else m_tbl.push_back(c[5:0]);
            default: begin
                case (c[1:0])
                    2'b00, 2'b01: if (!m_busy) begin
                        if (m_tbl.size() == 0) m_err = 1; else m_busy = 1;
                    end
                    2'b10: if (!m_busy) begin m_tbl.delete(); m_err = 0; end
                    default: m_err = 1;
                endcase
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic host_send(input logic [7:0] c);
        bit got = 0;
        host_cmd = c;
        host_cmd_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (clr_host_cmd_rdy === 1'b1) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL host_accept cmd=%h got=0 required=1", c); end
        @(posedge clk); #1;
        host_cmd_rdy = 1'b0;
        model_host(c);
    endtask

    task automatic serve_cmd(input logic [7:0] exp, input string tag);
        bit got = 0;
        bit stable = 1;
        logic [7:0] first;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) begin got = 1; break; end
        end
        checks++;
        if (!got || cmd !== exp) begin
            errors++;
            $display("FAIL %s cmd: got=%h rdy=%b required=%h", tag, cmd, cmd_rdy, exp);
        end
        first = cmd;
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            if (cmd !== first || cmd_rdy !== 1'b1) stable = 0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL %s hold: got=unstable required=stable", tag); end
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL %s drop: cmd_rdy=%b required=0", tag, cmd_rdy); end
    endtask

    task automatic travel();
        repeat ($urandom_range(0, 2)) tick();
        in_transit = 1'b1;
        repeat ($urandom_range(1, 5)) tick();
        in_transit = 1'b0;
    endtask

    // Cycles from arrival until the next GO appears (or route_done for the final stop).
    task automatic measure_dwell(input bit last, input string tag);
        int  gap = 0;
        bit  busy_ok = 1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            gap = i;
            if (!last && cmd_rdy === 1'b1) break;
            if (last && route_done === 1'b1) break;
            if (route_busy !== 1'b1) busy_ok = 0;
        end
        checks++;
        if (gap < DWELL + 1 || gap > DWELL + 4 || !busy_ok) begin
            errors++;
            $display("FAIL %s dwell: gap=%0d busy_ok=%0b required=%0d..%0d,1", tag, gap, busy_ok, DWELL + 1, DWELL + 4);
        end
        if (last) begin
            checks++;
            if (route_busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got=%b required=0", tag, route_busy); end
            @(negedge clk);
            checks++;
            if (route_done !== 1'b0) begin errors++; $display("FAIL %s done_width: got=%b required=0", tag, route_done); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_cmd = 8'h00; host_cmd_rdy = 1'b0;
        clr_cmd_rdy = 1'b0; in_transit = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cmd, cmd_rdy, route_busy, route_done, route_err, q_cnt, clr_host_cmd_rdy} !== '0) begin
            errors++;
            $display("FAIL reset: cmd=%h rdy=%b busy=%b done=%b err=%b q=%0d clrh=%b required=all0",
                     cmd, cmd_rdy, route_busy, route_done, route_err, q_cnt, clr_host_cmd_rdy);
        end
    endtask

    task automatic test_once_route();
        for (int t = 0; t < 4; t++) begin
            int n;
            int d0;
            host_send(8'hC2);
            n = (t == 0) ? 2 : $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                logic [5:0] id;
                id = (t == 0) ? ((k == 0) ? 6'h05 : 6'h09) : 6'($urandom);
                host_send({2'b10, id});
            end
            checks++;
            if (q_cnt !== 4'(m_tbl.size())) begin errors++; $display("FAIL once_qcnt: got=%0d required=%0d", q_cnt, m_tbl.size()); end
            d0 = done_cnt;
            host_send(8'hC0);
            checks++;
            if (route_busy !== 1'b1) begin errors++; $display("FAIL once_busy: got=%b required=1", route_busy); end
            for (int k = 0; k < n; k++) begin
                serve_cmd({2'b01, m_tbl[k]}, "once_go");
                travel();
                measure_dwell(k == n - 1, "once");
            end
            m_busy = 0;
            repeat (5) tick();
            checks++;
            if (done_cnt - d0 !== 1 || cmd_rdy !== 1'b0 || route_busy !== 1'b0 || route_err !== m_err) begin
                errors++;
                $display("FAIL once_end: done=%0d rdy=%b busy=%b err=%b required=1,0,0,%b",
                         done_cnt - d0, cmd_rdy, route_busy, route_err, m_err);
            end
        end
    endtask

    task automatic test_loop_stop();
        int d0;
        host_send(8'hC2);
        host_send(8'h85);
        host_send(8'h89);
        d0 = done_cnt;
        host_send(8'hC1);
        for (int lap = 0; lap < 2; lap++) begin
            for (int k = 0; k < 2; k++) begin
                serve_cmd({2'b01, m_tbl[k]}, "loop_go");
                if (lap == 1) break;
                travel();
                measure_dwell(0, "loop");
            end
        end
        host_send(8'h00);
        checks++;
        if (route_busy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy: got=%b required=0", route_busy); end
        serve_cmd(8'h00, "loop_stop");
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL loop_no_done: got=%0d required=0", done_cnt - d0); end
    endtask

    task automatic test_overflow();
        host_send(8'hC2);
        for (int k = 0; k < DEPTH + 1; k++) begin
            host_send({2'b10, 6'($urandom)});
            if (k == DEPTH - 1) begin
                checks++;
                if (q_cnt !== 4'(DEPTH) || route_err !== 1'b0) begin
                    errors++; $display("FAIL ovf_full: q=%0d err=%b required=%0d,0", q_cnt, route_err, DEPTH);
                end
            end
        end
        checks++;
        if (q_cnt !== 4'(m_tbl.size()) || route_err !== m_err || !m_err) begin
            errors++; $display("FAIL ovf_drop: q=%0d err=%b required=%0d,%b", q_cnt, route_err, m_tbl.size(), m_err);
        end
        host_send(8'hC2);
        checks++;
        if (q_cnt !== 4'd0 || route_err !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: q=%0d err=%b required=0,0", q_cnt, route_err);
        end
    endtask

    task automatic test_empty_run();
        bit quiet = 1;
        host_send(8'hC0);
        checks++;
        if (route_err !== m_err || route_busy !== 1'b0) begin
            errors++; $display("FAIL empty_run: err=%b busy=%b required=%b,0", route_err, route_busy, m_err);
        end
        repeat (10) begin @(negedge clk); if (cmd_rdy !== 1'b0) quiet = 0; end
        checks++;
        if (!quiet) begin errors++; $display("FAIL empty_run_cmd: cmd_rdy=1 required=0"); end
        host_send(8'hC2);
        host_send(8'hC3);
        checks++;
        if (route_err !== 1'b1) begin errors++; $display("FAIL reserved_err: got=%b required=1", route_err); end
        host_send(8'hC2);
    endtask

    task automatic test_back_to_back();
        bit held = 1;
        bit got = 0;
        host_send(8'h00);
        host_cmd = 8'h4A;
        host_cmd_rdy = 1'b1;
        repeat (8) begin @(negedge clk); if (clr_host_cmd_rdy !== 1'b0) held = 0; end
        checks++;
        if (!held || cmd !== 8'h00 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL b2b_block: held=%b cmd=%h rdy=%b required=1,00,1", held, cmd, cmd_rdy);
        end
        @(posedge clk); #1; clr_cmd_rdy = 1'b1;
        @(posedge clk); #1; clr_cmd_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (clr_host_cmd_rdy === 1'b1) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL b2b_accept: got=0 required=1"); end
        @(posedge clk); #1; host_cmd_rdy = 1'b0;
        model_host(8'h4A);
        serve_cmd(8'h4A, "b2b_fwd");
    endtask

    task automatic test_stop_at_terminal();
        bit quiet = 1;
        int d0;
        host_send(8'hC2);
        host_send(8'h85);
        host_send(8'h89);
        d0 = done_cnt;
        host_send(8'hC0);
        serve_cmd(8'h45, "term_go");
        travel();
        repeat (DWELL) tick();
        host_cmd = 8'h00;
        host_cmd_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (clr_host_cmd_rdy !== 1'b1) begin errors++; $display("FAIL term_accept: got=%b required=1", clr_host_cmd_rdy); end
        @(posedge clk); #1; host_cmd_rdy = 1'b0;
        model_host(8'h00);
        checks++;
        if (route_busy !== 1'b0 || cmd !== 8'h00 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL term_stop: busy=%b cmd=%h rdy=%b required=0,00,1", route_busy, cmd, cmd_rdy);
        end
        serve_cmd(8'h00, "term_fwd");
        repeat (12) begin
            @(negedge clk);
            if (cmd_rdy !== 1'b0 || route_busy !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet || done_cnt != d0) begin
            errors++; $display("FAIL term_quiet: quiet=%b done=%0d required=1,0", quiet, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_route();
        bit got = 0;
        host_send(8'hC2);
        host_send(8'h91);
        host_send(8'h92);
        host_send(8'hC1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) begin got = 1; break; end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!got || cmd_rdy !== 1'b0 || route_busy !== 1'b0 || q_cnt !== 4'd0 || cmd !== 8'h00) begin
            errors++; $display("FAIL mid_reset: seen=%b rdy=%b busy=%b q=%0d cmd=%h required=1,0,0,0,00",
                               got, cmd_rdy, route_busy, q_cnt, cmd);
        end
        m_tbl.delete(); m_err = 0; m_busy = 0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_once_route();
        test_loop_stop();
        test_overflow();
        test_empty_run();
        test_back_to_back();
        test_stop_at_terminal();
        test_reset_mid_route();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
